// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers,
// with grants capped at MAX_BURST words and no writes while the FIFO is full.
module fifo_rr_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    ack,
  input  logic                fifo_full,
  output logic                fifo_wr,
  output logic [DW-1:0]       fifo_data,
  output logic [N_REQ-1:0]    grant,
  output logic                busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0]    LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [BW-1:0]   burst_cnt;
  logic [DW-1:0]   words [N_REQ];
  logic            write_en;
  logic [IW-1:0]   pick_idx;

  // Search starts just after the previous grantee, so that grantee ranks lowest.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [IW-1:0]    l);
    logic [IW-1:0] sel;
    logic [IW-1:0] idx;
    logic          found;
    sel   = l;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx   = IW'((int'(l) + k) % N_REQ);
      sel   = (!found && r[idx]) ? idx : sel;
      found = found | r[idx];
    end
    return sel;
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      words[i] = req_data[i*DW +: DW];
    end
  end

  assign pick_idx = rr_pick(req, last);

  // A write happens whenever the grantee still requests and the FIFO has room.
  always_comb begin
    write_en  = 1'b0;
    ack       = {N_REQ{1'b0}};
    fifo_data = {DW{1'b0}};
    if ((state == GRANT) && req[last] && !fifo_full) begin
      write_en  = 1'b1;
      ack       = ONE_HOT0 << last;
      fifo_data = words[last];
    end else begin
      write_en  = 1'b0;
    end
  end

  assign fifo_wr = write_en;

  // `last` doubles as the index of the current grantee while in GRANT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= {N_REQ{1'b0}};
      burst_cnt <= {BW{1'b0}};
      last      <= IW'(N_REQ - 1);
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= GRANT;
            grant     <= ONE_HOT0 << pick_idx;
            last      <= pick_idx;
            burst_cnt <= {BW{1'b0}};
            busy      <= 1'b1;
          end else begin
            state     <= IDLE;
            grant     <= {N_REQ{1'b0}};
            busy      <= 1'b0;
          end
        end
        GRANT: begin
          if (write_en && (burst_cnt == LAST_BEAT)) begin
            state     <= IDLE;
            grant     <= {N_REQ{1'b0}};
            burst_cnt <= {BW{1'b0}};
            busy      <= 1'b0;
          end else if (write_en) begin
            burst_cnt <= burst_cnt + BW'(1);
          end else if (!req[last]) begin
            state     <= IDLE;
            grant     <= {N_REQ{1'b0}};
            burst_cnt <= {BW{1'b0}};
            busy      <= 1'b0;
          end else begin
            burst_cnt <= burst_cnt;
          end
        end
        default: begin
          state     <= IDLE;
          grant     <= {N_REQ{1'b0}};
          burst_cnt <= {BW{1'b0}};
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Self-checking bench for fifo_rr_wr_arbiter: vector table, directed corner
// sequences and random traffic against a transaction-level reference model.
module tb_fifo_rr_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  ack;
  logic          fifo_full;
  logic          fifo_wr;
  logic [DW-1:0] fifo_data;
  logic [N-1:0]  grant;
  logic          busy;

  fifo_rr_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_data(fifo_data),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: who owns the port (-1 = nobody), words written this grant, last grantee.
  int m_owner = -1;
  int m_words = 0;
  int m_last  = N - 1;

  logic [N-1:0]  s_grant, s_ack;
  logic          s_wr, s_busy;
  logic [DW-1:0] s_data;
  logic [DW-1:0] wlog [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int i);
    return req_data[i*DW +: DW];
  endfunction

  // One clock cycle: drive, sample at the falling edge, compare with model, advance model.
  task automatic step(input logic r, input logic [N-1:0] q, input logic f);
    bit e_wr;
    rst = r; req = q; fifo_full = f;
    #4;
    s_grant = grant; s_ack = ack; s_wr = fifo_wr; s_busy = busy; s_data = fifo_data;
    if (s_wr) wlog.push_back(s_data);
    e_wr = (m_owner >= 0) && q[m_owner] && !f;
    if (chk_en) begin
      check("grant", 32'(s_grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("busy",  32'(s_busy),  32'(m_owner >= 0));
      check("fifo_wr", 32'(s_wr),  32'(e_wr));
      check("ack", 32'(s_ack), e_wr ? (32'd1 << m_owner) : 32'd0);
      if (e_wr) check("fifo_data", 32'(s_data), 32'(word_of(m_owner)));
      else if (m_owner < 0) check("idle_data", 32'(s_data), 32'd0);
    end
    if (r) begin
      m_owner = -1; m_words = 0; m_last = N - 1;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && q[(m_last + k) % N]) m_owner = (m_last + k) % N;
      end
      if (m_owner >= 0) begin
        m_last = m_owner; m_words = 0;
      end
    end else if (e_wr) begin
      m_words++;
      if (m_words == MB) m_owner = -1;
    end else if (!q[m_owner]) begin
      m_owner = -1;
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic          full;
    logic [N-1:0]  grant;
    logic          wr;
    logic [N-1:0]  ack;
    logic          busy;
    logic [DW-1:0] data;
  } vec_t;

  vec_t tbl [11];
  logic [N-1:0] rq;

  initial begin
    rst = 1'b1; req = '0; fifo_full = 1'b0; req_data = 32'h44332211;
    tbl[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11};
    tbl[3]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11};
    tbl[4]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11};
    tbl[5]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11};
    tbl[6]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'h00};
    tbl[8]  = '{1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'h00};
    tbl[9]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h33};

    @(posedge clk); #1;
    step(1'b1, 4'b1111, 1'b0);
    chk_en = 1'b1;

    // Vector table: reset, single burst of req0, stall, early release, grant to req2.
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].full);
      check($sformatf("tbl%0d_grant", i), 32'(s_grant), 32'(tbl[i].grant));
      check($sformatf("tbl%0d_wr", i),    32'(s_wr),    32'(tbl[i].wr));
      check($sformatf("tbl%0d_ack", i),   32'(s_ack),   32'(tbl[i].ack));
      check($sformatf("tbl%0d_busy", i),  32'(s_busy),  32'(tbl[i].busy));
      if (!tbl[i].full) check($sformatf("tbl%0d_data", i), 32'(s_data), 32'(tbl[i].data));
    end

    // Reset with all requests, then round robin 0,1,2,3,0 with 4 words each.
    step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    check("t1_grant_after_rst", 32'(s_grant), 32'd0);
    check("t1_wr_after_rst", 32'(s_wr), 32'd0);
    wlog.delete();
    for (int c = 0; c < 25; c++) step(1'b0, 4'b1111, 1'b0);
    check("t3_word_count", wlog.size(), 32'd20);
    for (int j = 0; j < 20 && j < wlog.size(); j++)
      check($sformatf("t3_word%0d", j), 32'(wlog[j]), 32'(word_of((j / 4) % 4)));

    // Full stall mid-burst: 2 words, 5 stall cycles, then exactly 2 more words.
    step(1'b0, 4'b0000, 1'b0);
    wlog.delete();
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 4'b0001, 1'b1);
      check("t4_stall_grant", 32'(s_grant), 32'b0001);
      check("t4_stall_wr", 32'(s_wr), 32'd0);
    end
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    check("t4_released", 32'(s_busy), 32'd0);
    check("t4_word_count", wlog.size(), 32'd4);

    // Early release of req1 after one write, pending req2 served next.
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0010, 1'b0);
    step(1'b0, 4'b0110, 1'b0);
    check("t5_first_ack", 32'(s_ack), 32'b0010);
    step(1'b0, 4'b0100, 1'b0);
    check("t5_drop_wr", 32'(s_wr), 32'd0);
    step(1'b0, 4'b0100, 1'b0);
    check("t5_idle", 32'(s_busy), 32'd0);
    step(1'b0, 4'b0100, 1'b0);
    check("t5_grant2", 32'(s_grant), 32'b0100);

    // Reset during a write of req3; arbitration restarts at req0.
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    step(1'b1, 4'b1000, 1'b0);
    check("t6_write_during_rst", 32'(s_ack), 32'b1000);
    step(1'b0, 4'b1001, 1'b0);
    check("t6_grant_cleared", 32'(s_grant), 32'd0);
    check("t6_no_wr", 32'(s_wr), 32'd0);
    step(1'b0, 4'b1001, 1'b0);
    check("t6_restart_req0", 32'(s_grant), 32'b0001);

    // Random traffic: requesters mostly hold until acked, occasional drops and resets.
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      logic r, f;
      r = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 9) < 3);
      step(r, rq, f);
      for (int i = 0; i < N; i++) begin
        if (s_ack[i] || (rq[i] && $urandom_range(0, 29) == 0)) rq[i] = 1'b0;
        else if (!rq[i] && $urandom_range(0, 9) < 4) begin
          rq[i] = 1'b1;
          req_data[i*DW +: DW] = DW'($urandom);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
